// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM multi-register transfer sequencer.
//   state_t     : FSM encoding (IDLE/XFER/DONE)
//   REG_SEL_MEM : register-file write-back select for memory data
//   R7_SEL_MEM  : R7 data select for memory data
//   R7_IDX      : mask index that routes to the dedicated R7 write port
package lm_sm_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] REG_SEL_MEM = 2'b00;
    localparam logic [2:0] R7_SEL_MEM  = 3'b001;
    localparam logic [2:0] R7_IDX      = 3'd7;

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// Request/memory/register-file bundle of the LM/SM sequencer.
//   master : pipeline/memory side (drives start, isLoad, mask, baseAddr, memReady)
//   slave  : sequencer side (drives busy, stall, memory strobes, register writes, done)
interface lm_sm_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int MASK_W = 8
);
    logic              start;
    logic              isLoad;
    logic [MASK_W-1:0] mask;
    logic [ADDR_W-1:0] baseAddr;
    logic              memReady;

    logic              busy;
    logic              pipeStall;
    logic [ADDR_W-1:0] memAddr;
    logic              memReadEn;
    logic              memWriteEn;
    logic [2:0]        regAddr;
    logic              regWriteEn;
    logic [1:0]        regSelect;
    logic              r7WriteEn;
    logic [2:0]        r7Select;
    logic              done;

    modport master (
        output start, isLoad, mask, baseAddr, memReady,
        input  busy, pipeStall, memAddr, memReadEn, memWriteEn, regAddr,
               regWriteEn, regSelect, r7WriteEn, r7Select, done
    );

    modport slave (
        input  start, isLoad, mask, baseAddr, memReady,
        output busy, pipeStall, memAddr, memReadEn, memWriteEn, regAddr,
               regWriteEn, regSelect, r7WriteEn, r7Select, done
    );
endinterface

// File: rtl/lm_sm_sequencer_priority_encoder_8.sv
// Lowest-set-bit finder for the 8-bit remaining-register mask.
//   vec   : input vector
//   idx   : index of the lowest set bit (0 when vec is zero)
//   valid : vec has at least one bit set
module priority_encoder_8 (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       valid
);
    always_comb begin
        idx   = 3'd0;
        valid = |vec;
        // Scan from the top down so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
    end
endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks the register mask lowest bit first, issuing one
// memory access per selected register at consecutive addresses while the
// upstream pipeline is stalled, then pulses done for one cycle.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of lm_sm_sequencer_if (request in, memory strobes,
//                register-file write controls, busy/stall/done out)
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int MASK_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    lm_sm_sequencer_if.slave   bus
);
    state_t            state, state_nx;
    logic [MASK_W-1:0] remMask, rem_nx;
    logic [ADDR_W-1:0] addrReg, addr_nx;
    logic              dirReg, dir_nx;

    logic [7:0]        enc_in;
    logic [2:0]        cur_idx;
    logic              cur_vld;
    logic [MASK_W-1:0] cur_bit;

    // Mask is at most 8 registers wide; narrower masks are zero-extended.
    assign enc_in  = 8'(remMask);
    assign cur_bit = MASK_W'(1) << cur_idx;

    priority_encoder_8 u_penc (
        .vec   (enc_in),
        .idx   (cur_idx),
        .valid (cur_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            remMask <= '0;
            addrReg <= '0;
            dirReg  <= 1'b0;
        end else begin
            state   <= state_nx;
            remMask <= rem_nx;
            addrReg <= addr_nx;
            dirReg  <= dir_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = remMask;
        addr_nx  = addrReg;
        dir_nx   = dirReg;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    rem_nx   = bus.mask;
                    addr_nx  = bus.baseAddr;
                    dir_nx   = bus.isLoad;
                    state_nx = (|bus.mask) ? XFER : DONE;
                end
            end
            XFER: begin
                if (!cur_vld) begin
                    // Unreachable with a nonzero latched mask; recover cleanly.
                    state_nx = DONE;
                end else if (bus.memReady) begin
                    rem_nx   = remMask & ~cur_bit;
                    addr_nx  = addrReg + ADDR_W'(1);
                    if (rem_nx == '0) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state != IDLE);
        bus.pipeStall  = ((state == IDLE) && bus.start) || (state == XFER);
        bus.memAddr    = '0;
        bus.memReadEn  = 1'b0;
        bus.memWriteEn = 1'b0;
        bus.regAddr    = 3'd0;
        bus.regWriteEn = 1'b0;
        bus.r7WriteEn  = 1'b0;
        bus.regSelect  = REG_SEL_MEM;
        bus.r7Select   = R7_SEL_MEM;
        bus.done       = (state == DONE);
        if (state == XFER) begin
            bus.memAddr    = addrReg;
            bus.regAddr    = cur_idx;
            bus.memReadEn  = dirReg;
            bus.memWriteEn = !dirReg;
            // R7 (PC) has its own write port; loads commit only on memReady.
            if (dirReg && bus.memReady) begin
                bus.regWriteEn = (cur_idx != R7_IDX);
                bus.r7WriteEn  = (cur_idx == R7_IDX);
            end
        end
    end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lm_sm_sequencer_if #(.ADDR_W(16), .MASK_W(8)) bus ();
    lm_sm_sequencer #(.ADDR_W(16), .MASK_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  r;
        logic [15:0] a;
        logic        ld;
    } acc_t;

    acc_t sb[$];
    int checks = 0, failures = 0;
    int cyc, done_cnt, done_cyc, stall_cnt, strobe_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_xfer(input logic ld, input logic [7:0] m, input logic [15:0] base);
        logic [15:0] a;
        a = base;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                sb.push_back('{r: 3'(i), a: a, ld: ld});
                a = a + 16'd1;
            end
        end
    endtask

    task automatic sample();
        acc_t e;
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (bus.pipeStall) stall_cnt++;
        if (bus.memReadEn || bus.memWriteEn) begin
            strobe_cnt++;
            chk("access_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb[0];
                chk("memAddr", bus.memAddr, e.a);
                chk("regAddr", bus.regAddr, e.r);
                chk("memReadEn", bus.memReadEn, e.ld);
                chk("memWriteEn", bus.memWriteEn, !e.ld);
                chk("regWriteEn", bus.regWriteEn, e.ld && bus.memReady && e.r != 3'd7);
                chk("r7WriteEn", bus.r7WriteEn, e.ld && bus.memReady && e.r == 3'd7);
                if (bus.memReady) void'(sb.pop_front());
            end
        end else begin
            chk("we_no_access", {bus.regWriteEn, bus.r7WriteEn}, 0);
        end
    endtask

    // Drive one cycle's inputs, observe its outputs, then advance.
    task automatic cycle(input logic s, input logic rdy);
        bus.start = s;
        bus.memReady = rdy;
        #1;
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_test();
        cyc = 0; done_cnt = 0; done_cyc = -1; stall_cnt = 0; strobe_cnt = 0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_pipeStall"}, bus.pipeStall, 0);
        chk({tag, "_memAddr"}, bus.memAddr, 0);
        chk({tag, "_rd_wr"}, {bus.memReadEn, bus.memWriteEn}, 0);
        chk({tag, "_regAddr"}, bus.regAddr, 0);
        chk({tag, "_we"}, {bus.regWriteEn, bus.r7WriteEn}, 0);
        chk({tag, "_regSelect"}, bus.regSelect, 2'b00);
        chk({tag, "_r7Select"}, bus.r7Select, 3'b001);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.isLoad = 1'b0; bus.mask = '0;
        bus.baseAddr = '0; bus.memReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset");
        reset = 1'b0;
        begin_test();

        // LM R0,R2,R7 from 0x0100
        begin_test();
        bus.isLoad = 1'b1; bus.mask = 8'b1000_0101; bus.baseAddr = 16'h0100;
        push_xfer(1'b1, 8'b1000_0101, 16'h0100);
        cycle(1'b1, 1'b1);
        repeat (5) cycle(1'b0, 1'b1);
        chk("t1_done_cyc", done_cyc, 4);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_stall", stall_cnt, 4);
        chk("t1_strobes", strobe_cnt, 3);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_idle", bus.busy, 0);

        // SM all registers, address wraps past 0xFFFF
        begin_test();
        bus.isLoad = 1'b0; bus.mask = 8'hFF; bus.baseAddr = 16'hFFFE;
        push_xfer(1'b0, 8'hFF, 16'hFFFE);
        cycle(1'b1, 1'b1);
        repeat (10) cycle(1'b0, 1'b1);
        chk("t2_done_cyc", done_cyc, 9);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_stall", stall_cnt, 9);
        chk("t2_strobes", strobe_cnt, 8);
        chk("t2_sb_empty", sb.size(), 0);

        // LM with memReady low in cycles 1-2
        begin_test();
        bus.isLoad = 1'b1; bus.mask = 8'h03; bus.baseAddr = 16'h0040;
        push_xfer(1'b1, 8'h03, 16'h0040);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b1);
        chk("t3_done_cyc", done_cyc, 5);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_stall", stall_cnt, 5);
        chk("t3_strobes", strobe_cnt, 4);
        chk("t3_sb_empty", sb.size(), 0);

        // Empty mask: straight to DONE, no access
        begin_test();
        bus.isLoad = 1'b1; bus.mask = 8'h00; bus.baseAddr = 16'h1234;
        cycle(1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b1);
        chk("t4_done_cyc", done_cyc, 1);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_stall", stall_cnt, 1);
        chk("t4_strobes", strobe_cnt, 0);

        // start while busy is ignored; reset aborts mid-transfer
        begin_test();
        bus.isLoad = 1'b1; bus.mask = 8'h0F; bus.baseAddr = 16'h0200;
        push_xfer(1'b1, 8'h0F, 16'h0200);
        cycle(1'b1, 1'b1);
        bus.isLoad = 1'b0; bus.mask = 8'hF0; bus.baseAddr = 16'h0900;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        reset = 1'b1;
        cycle(1'b1, 1'b0);
        sb.delete();
        bus.start = 1'b0;
        #1;
        check_reset_outs("abort");
        cycle(1'b1, 1'b1);
        chk("t5_reset_over_start", bus.busy, 0);
        reset = 1'b0;
        chk("t5_no_done", done_cnt, 0);
        chk("t5_strobes", strobe_cnt, 3);

        begin_test();
        bus.isLoad = 1'b0; bus.mask = 8'h01; bus.baseAddr = 16'h0300;
        push_xfer(1'b0, 8'h01, 16'h0300);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        chk("t5_restart_done_cyc", done_cyc, 2);
        chk("t5_restart_strobes", strobe_cnt, 1);
        chk("t5_restart_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 16, which sets the memory address width.
REQ-002 The block SHALL have the parameter MASK_W, default 8, which sets the register-mask width (one bit per architectural register R0..R7).
REQ-003 The block SHALL have the port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have the port start  input  1  pulse that requests a multi-register transfer (LM/SM in memory stage).
REQ-006 The block SHALL have the port isLoad  input  1  transfer direction: 1 = LM (memory to register), 0 = SM (register to memory).
REQ-007 The block SHALL have the port mask  input  MASK_W  Imm[7:0] register mask; bit i selects Ri.
REQ-008 The block SHALL have the port baseAddr  input  ADDR_W  start address (RA contents).
REQ-009 The block SHALL have the port memReady  input  1  memory completes the current access this cycle.
REQ-010 The block SHALL have the port busy  output  1  sequencer not idle.
REQ-011 The block SHALL have the port pipeStall  output  1  freeze upstream pipeline stages.
REQ-012 The block SHALL have the port memAddr  output  ADDR_W  address of the current access.
REQ-013 The block SHALL have the port memReadEn and memWriteEn  output  1 each  memory strobes.
REQ-014 The block SHALL have the port regAddr  output  3  register being read (SM) or written (LM).
REQ-015 The block SHALL have the port regWriteEn  output  1  general register-file write enable (R0..R6).
REQ-016 The block SHALL have the port regSelect  output  2  write-back data select; fixed at 2'b00 (MemData).
REQ-017 The block SHALL have the port r7WriteEn  output  1  R7 write enable.
REQ-018 The block SHALL have the port r7Select  output  3  R7 data select; fixed at 3'b001 (MemData).
REQ-019 The block SHALL have the port done  output  1  one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have the states IDLE, XFER and DONE, with busy = (state != IDLE).
REQ-021 In IDLE, start=1 SHALL latch mask into remMask, baseAddr into addrReg and isLoad into dirReg. The next state SHALL be XFER if mask != 0 and DONE if mask == 0.
REQ-022 In XFER, the current register SHALL be the lowest set bit of remMask: regAddr = its index and memAddr = addrReg.
REQ-023 In XFER with dirReg=1, memReadEn=1. Writes SHALL be qualified by memReady: regWriteEn=1 for index 0..6, and r7WriteEn=1 (never regWriteEn) for index 7.
REQ-024 In XFER with dirReg=0, memWriteEn=1 and no register write enable SHALL assert.
REQ-025 When memReady=1 in XFER, the current bit SHALL be cleared in remMask and addrReg SHALL increment by 1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
REQ-026 When memReady=1 in XFER and the cleared remMask is 0, the next state SHALL be DONE.
REQ-027 When memReady=0 in XFER, state, remMask, addrReg and all outputs SHALL hold.
REQ-028 In DONE, done=1 for exactly one cycle and the next state SHALL be IDLE.
REQ-029 pipeStall SHALL equal (state==IDLE and start) or (state==XFER), and SHALL be 0 in DONE.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 All strobes and write enables SHALL be 0 outside XFER.
REQ-032 Latency with memReady held at 1 and N set mask bits (N ≥ 1): start accepted in cycle 0, accesses in cycles 1..N, done in cycle N+1, IDLE in cycle N+2.
REQ-033 For mask == 0: start in cycle 0, done in cycle 1, and no memory access SHALL occur.

Reset
REQ-034 When reset=1 at a clock edge, state SHALL become IDLE, and remMask, addrReg and dirReg SHALL become 0.
REQ-035 After reset, all outputs SHALL be 0 except regSelect=2'b00 and r7Select=3'b001.
REQ-036 Reset SHALL abort an in-progress transfer with no done pulse. Reset SHALL take priority over start.

Structure
REQ-037 The shared package SHALL hold the state encoding (IDLE=2'd0, XFER=2'd1, DONE=2'd2), REG_SEL_MEM=2'b00 and R7_SEL_MEM=3'b001.
REQ-038 The lowest-set-bit search SHALL be one sub-module, priority_encoder_8: 8-bit input, 3-bit index and valid outputs.

Verification
REQ-039 LM, mask=8'b1000_0101, baseAddr=0x0100, memReady=1 -> regWriteEn for R0@0x0100 and R2@0x0101, r7WriteEn for R7@0x0102, done in cycle 4.
REQ-040 SM, mask=8'hFF, baseAddr=0xFFFE -> eight memWriteEn cycles with addresses 0xFFFE, 0xFFFF, 0x0000..0x0005, done in cycle 9, no register writes.
REQ-041 LM, mask=8'h03, memReady low in cycles 1-2 -> R0 access at the same address is held for 3 cycles, no write until memReady=1, done in cycle 5.
REQ-042 start with mask=0 -> done in cycle 1, pipeStall only in cycle 0, no strobes.
REQ-043 start re-asserted while busy, then reset in XFER -> the second start is ignored; after reset all outputs are at reset values, no done pulse, and the next start is accepted normally.
